fp_sub_serial: RTL and testbench

FP_SUB_SERIAL -- requirements
Module: fp_sub_serial

---
 rtl/fp_sub_serial.sv | 113 +++++++++++
 tb/tb_fp_sub_serial.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_sub_serial.sv
// Serial modular subtractor: diff = (a - b) mod P, one limb per cycle.
// Latency NUM_LIMBS+1 accept-to-valid, 2*NUM_LIMBS+1 with wrap; single op in flight, holds result until out_ready.
module fp_sub_serial #(
    parameter int LIMB_W = 64,
    parameter int NUM_LIMBS = 6,
    parameter logic [380:0] P = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [380:0] a,
    input  logic [380:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [380:0] diff
);
    localparam int W = LIMB_W * NUM_LIMBS;
    localparam int IDX_W = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_LIMBS - 1);
    localparam logic [W-1:0] P_EXT = {{(W-381){1'b0}}, P};

    typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, b_q, res_q;
    logic [IDX_W-1:0] idx_q;
    logic             cb_q;
    logic             last;
    logic [LIMB_W-1:0] lhs, rhs;
    logic [LIMB_W:0]  sub_w, add_w;

    // Operands shift right one limb per cycle so the active limb is always
    // at bit 0; results shift in from the top and land in place after the pass.
    assign lhs   = (state_q == FIX) ? res_q[LIMB_W-1:0] : a_q[LIMB_W-1:0];
    assign rhs   = b_q[LIMB_W-1:0];
    assign sub_w = {1'b0, lhs} - {1'b0, rhs} - {{LIMB_W{1'b0}}, cb_q};
    assign add_w = {1'b0, lhs} + {1'b0, rhs} + {{LIMB_W{1'b0}}, cb_q};
    assign last  = (idx_q == LAST);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SUB;
            end
            SUB:  if (last) state_d = sub_w[LIMB_W] ? FIX : DONE;
            FIX:  if (last) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            idx_q <= '0;
            cb_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= {{(W-381){1'b0}}, a};
                        b_q   <= {{(W-381){1'b0}}, b};
                        idx_q <= '0;
                        cb_q  <= 1'b0;
                    end
                end
                SUB: begin
                    a_q   <= a_q >> LIMB_W;
                    b_q   <= b_q >> LIMB_W;
                    res_q <= {sub_w[LIMB_W-1:0], res_q[W-1:LIMB_W]};
                    if (last) begin
                        // Preload the modulus for a possible correction pass.
                        b_q   <= P_EXT;
                        idx_q <= '0;
                        cb_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                        cb_q  <= sub_w[LIMB_W];
                    end
                end
                FIX: begin
                    b_q   <= b_q >> LIMB_W;
                    res_q <= {add_w[LIMB_W-1:0], res_q[W-1:LIMB_W]};
                    if (last) begin
                        idx_q <= '0;
                        cb_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                        cb_q  <= add_w[LIMB_W];
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = res_q[380:0];
endmodule

// File: tb/tb_fp_sub_serial.sv
// Directed and randomized checks of fp_sub_serial against hand values and a
// modular-arithmetic scoreboard.
module tb_fp_sub_serial;
    localparam logic [380:0] P = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [380:0] a = '0;
    logic [380:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [380:0] diff;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fp_sub_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff)
    );

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [380:0] rnd_fe();
        logic [383:0] v;
        v = '0;
        for (int i = 0; i < 12; i++) v = {v[351:0], 32'($urandom)};
        v[383:381] = 3'b0;
        if (v >= {3'b0, P}) v = v - {3'b0, P};
        return v[380:0];
    endfunction

    function automatic logic [380:0] model(input logic [380:0] x, input logic [380:0] y);
        logic [381:0] t;
        if (x >= y) t = {1'b0, x} - {1'b0, y};
        else        t = {1'b0, x} + {1'b0, P} - {1'b0, y};
        return t[380:0];
    endfunction

    // Called just after a falling edge; returns just after a falling edge.
    task automatic run_op(input string tag, input logic [380:0] op_a, input logic [380:0] op_b,
                          input logic [380:0] exp_d, input int exp_lat);
        int cyc;
        chk({tag, "_in_ready_pre"}, 384'(in_ready), 384'(1));
        a = op_a;
        b = op_b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (!out_valid) begin
                in_valid = 1'b1;
                a = rnd_fe();
                b = rnd_fe();
            end else begin
                in_valid = 1'b0;
            end
        end while (!out_valid && cyc < 40);
        in_valid = 1'b0;
        chk({tag, "_latency"}, 384'(cyc), 384'(exp_lat));
        chk({tag, "_diff"}, {3'b0, diff}, {3'b0, exp_d});
        @(negedge clk);
        chk({tag, "_in_ready_post"}, 384'(in_ready), 384'(1));
        chk({tag, "_valid_drop"}, 384'(out_valid), 384'(0));
    endtask

    initial begin
        logic [380:0] q[$];
        logic [380:0] exp_d;
        int cyc;
        int seen;
        int acc;
        int dlv;
        int cycles;
        int rst_at[2];

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 384'(in_ready), 384'(1));
        chk("rst_out_valid", 384'(out_valid), 384'(0));
        chk("rst_diff", {3'b0, diff}, 384'(0));
        rst_n = 1'b1;

        run_op("sub_5_3", 381'd5, 381'd3, 381'd2, 7);
        run_op("sub_3_5", 381'd3, 381'd5, P - 381'd2, 13);
        run_op("sub_0_pm1", 381'd0, P - 381'd1, 381'd1, 13);
        run_op("sub_pm1_pm1", P - 381'd1, P - 381'd1, 381'd0, 7);

        // Consumer stalls four cycles after the result appears.
        a = 381'd100;
        b = 381'd30;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b0;
        end while (!out_valid && cyc < 40);
        chk("bp_latency", 384'(cyc), 384'(7));
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = rnd_fe();
            b = rnd_fe();
            @(negedge clk);
            chk("bp_hold_valid", 384'(out_valid), 384'(1));
            chk("bp_hold_diff", {3'b0, diff}, 384'(70));
            chk("bp_hold_in_ready", 384'(in_ready), 384'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 384'(out_valid), 384'(0));
        chk("bp_release_in_ready", 384'(in_ready), 384'(1));
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("bp_no_ghost", 384'(seen), 384'(0));

        // Reset mid-SUB and mid-FIX abandons the operation.
        rst_at[0] = 3;
        rst_at[1] = 9;
        for (int k = 0; k < 2; k++) begin
            a = 381'd3;
            b = 381'd5;
            in_valid = 1'b1;
            out_ready = 1'b1;
            @(posedge clk);
            for (int c = 1; c <= rst_at[k]; c++) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            rst_n = 1'b0;
            #1;
            chk("rst_mid_in_ready", 384'(in_ready), 384'(1));
            chk("rst_mid_out_valid", 384'(out_valid), 384'(0));
            chk("rst_mid_diff", {3'b0, diff}, 384'(0));
            @(negedge clk);
            rst_n = 1'b1;
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("rst_mid_no_result", 384'(seen), 384'(0));
        end
        run_op("sub_9_4", 381'd9, 381'd4, 381'd5, 7);

        // Randomized traffic against the scoreboard.
        acc = 0;
        dlv = 0;
        cycles = 0;
        in_valid = 1'b0;
        while (dlv < 1000 && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid = (acc < 1000) && ($urandom_range(0, 2) != 0);
            a = rnd_fe();
            b = rnd_fe();
            if (in_valid && in_ready) begin
                q.push_back(model(a, b));
                acc++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_extra_result", 384'(1), 384'(0));
                end else begin
                    exp_d = q.pop_front();
                    chk("rnd_diff", {3'b0, diff}, {3'b0, exp_d});
                end
                dlv++;
            end
        end
        in_valid = 1'b0;
        chk("rnd_delivered", 384'(dlv), 384'(1000));
        chk("rnd_pending", 384'(q.size()), 384'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
